// File: rtl/btn_debounce.sv
// Button input conditioner: 2-flop synchroniser, per-channel debounce FSM and
// single-cycle press/release pulses, with a VIO override path that skips debounce.
module btn_debounce #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] vio_btn,
  input  logic             vio_select,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S0   = 2'd0;
  localparam logic [1:0] CHK1 = 2'd1;
  localparam logic [1:0] S1   = 2'd2;
  localparam logic [1:0] CHK0 = 2'd3;

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] vio_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vio_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      vio_q   <= vio_btn;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, release_q;
    logic             s_raw;
    logic             s_vio;

    assign s_raw = sync2_q[gi];
    assign s_vio = vio_q[gi];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      if (vio_select) begin
        // Keep the FSM parked in the stable state that matches the override so
        // switching back to the raw path resumes from a consistent level.
        state_d = s_vio ? S1 : S0;
        cnt_d   = '0;
        level_d = s_vio;
      end else begin
        case (state_q)
          S0: begin
            if (s_raw) begin
              state_d = CHK1;
              cnt_d   = '0;
            end
          end
          CHK1: begin
            if (!s_raw) begin
              state_d = S0;
            end else if (cnt_q == CNT_MAX) begin
              state_d = S1;
              cnt_d   = '0;
              level_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          S1: begin
            if (!s_raw) begin
              state_d = CHK0;
              cnt_d   = '0;
            end
          end
          CHK0: begin
            if (s_raw) begin
              state_d = S1;
            end else if (cnt_q == CNT_MAX) begin
              state_d = S0;
              cnt_d   = '0;
              level_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = S0;
            cnt_d   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= S0;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= level_d & ~level_q;
        release_q <= ~level_d & level_q;
      end
    end

    assign btn_level[gi]   = level_q;
    assign btn_press[gi]   = press_q;
    assign btn_release[gi] = release_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=8, N_BTN=3.
module tb_btn_debounce;

  localparam int NB = 3;
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] vio_btn;
  logic          vio_select;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int n_vec = 0;
  int n_bad = 0;
  int press_tot [NB];
  int rel_tot   [NB];
  int press_base[NB];
  int rel_base  [NB];

  btn_debounce #(.N_BTN(NB), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .vio_btn    (vio_btn),
    .vio_select (vio_select),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // Pulses last a full cycle, so one negedge sample counts each exactly once.
  initial begin
    for (int i = 0; i < NB; i++) begin
      press_tot[i] = 0;
      rel_tot[i]   = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (btn_press[i] === 1'b1)   press_tot[i] = press_tot[i] + 1;
      if (btn_release[i] === 1'b1) rel_tot[i]   = rel_tot[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mark();
    for (int i = 0; i < NB; i++) begin
      press_base[i] = press_tot[i];
      rel_base[i]   = rel_tot[i];
    end
  endtask

  task automatic check_counts(input string tag, input int p0, input int p1, input int p2,
                              input int r0, input int r1, input int r2);
    check({tag, " press0"}, 32'(press_tot[0] - press_base[0]), 32'(p0));
    check({tag, " press1"}, 32'(press_tot[1] - press_base[1]), 32'(p1));
    check({tag, " press2"}, 32'(press_tot[2] - press_base[2]), 32'(p2));
    check({tag, " rel0"},   32'(rel_tot[0] - rel_base[0]),     32'(r0));
    check({tag, " rel1"},   32'(rel_tot[1] - rel_base[1]),     32'(r1));
    check({tag, " rel2"},   32'(rel_tot[2] - rel_base[2]),     32'(r2));
  endtask

  initial begin
    // 1: reset with all inputs high, then all three buttons held
    reset_n    = 1'b0;
    btn_raw    = 3'b111;
    vio_btn    = 3'b111;
    vio_select = 1'b1;
    tick(3);
    check("t1 rst level",   32'(btn_level),   32'h0);
    check("t1 rst press",   32'(btn_press),   32'h0);
    check("t1 rst release", 32'(btn_release), 32'h0);
    vio_select = 1'b0;
    vio_btn    = 3'b000;
    reset_n    = 1'b1;
    tick(10);
    check("t1 e10 level", 32'(btn_level), 32'h0);
    check("t1 e10 press", 32'(btn_press), 32'h0);
    tick(1);
    check("t1 e11 level", 32'(btn_level), 32'h7);
    check("t1 e11 press", 32'(btn_press), 32'h7);
    tick(1);
    check("t1 e12 press", 32'(btn_press), 32'h0);
    check("t1 e12 level", 32'(btn_level), 32'h7);
    btn_raw = 3'b000;
    tick(11);
    check("t1 drop level",   32'(btn_level),   32'h0);
    check("t1 drop release", 32'(btn_release), 32'h7);
    tick(1);
    check("t1 drop rel end", 32'(btn_release), 32'h0);

    // 2: single button press and release
    mark();
    btn_raw = 3'b001;
    tick(10);
    check("t2 e10 level", 32'(btn_level), 32'h0);
    tick(1);
    check("t2 e11 level", 32'(btn_level), 32'h1);
    check("t2 e11 press", 32'(btn_press), 32'h1);
    tick(1);
    check("t2 e12 press", 32'(btn_press), 32'h0);
    tick(8);
    btn_raw = 3'b000;
    tick(10);
    check("t2 rel e10 level", 32'(btn_level), 32'h1);
    tick(1);
    check("t2 rel e11 level",   32'(btn_level),   32'h0);
    check("t2 rel e11 release", 32'(btn_release), 32'h1);
    tick(1);
    check("t2 rel e12 release", 32'(btn_release), 32'h0);
    check_counts("t2", 1, 0, 0, 1, 0, 0);

    // 3: short pulse is rejected
    mark();
    btn_raw = 3'b010;
    tick(5);
    btn_raw = 3'b000;
    tick(20);
    check("t3 level", 32'(btn_level), 32'h0);
    check_counts("t3", 0, 0, 0, 0, 0, 0);

    // 4: bouncing input, then held
    mark();
    for (int k = 0; k < 10; k++) begin
      btn_raw[2] = (k % 2 == 0);
      tick(3);
    end
    btn_raw[2] = 1'b1;
    tick(10);
    check("t4 e10 level", 32'(btn_level), 32'h0);
    check_counts("t4 pre", 0, 0, 0, 0, 0, 0);
    tick(1);
    check("t4 e11 level", 32'(btn_level), 32'h4);
    check("t4 e11 press", 32'(btn_press), 32'h4);
    tick(10);
    check_counts("t4 post", 0, 0, 1, 0, 0, 0);

    // 5: VIO override path and switching back
    mark();
    vio_btn    = 3'b000;
    vio_select = 1'b1;
    btn_raw    = 3'b111;
    tick(1);
    check("t5 switch level",   32'(btn_level),   32'h0);
    check("t5 switch release", 32'(btn_release), 32'h4);
    tick(3);
    mark();
    vio_btn = 3'b010;
    tick(1);
    check("t5 vio e1 level", 32'(btn_level), 32'h0);
    tick(1);
    check("t5 vio e2 level", 32'(btn_level), 32'h2);
    check("t5 vio e2 press", 32'(btn_press), 32'h2);
    tick(20);
    check("t5 vio hold level", 32'(btn_level), 32'h2);
    check_counts("t5 vio", 0, 1, 0, 0, 0, 0);
    mark();
    vio_select = 1'b0;
    tick(8);
    check("t5 back e8 level", 32'(btn_level), 32'h2);
    tick(1);
    check("t5 back e9 level", 32'(btn_level), 32'h7);
    check("t5 back e9 press", 32'(btn_press), 32'h5);
    tick(5);
    check_counts("t5 back", 1, 0, 1, 0, 0, 0);

    // 6: reset while a press is being debounced
    btn_raw = 3'b100;
    tick(12);
    check("t6 setup level", 32'(btn_level), 32'h4);
    mark();
    btn_raw = 3'b101;
    tick(5);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 async level",   32'(btn_level),   32'h0);
    check("t6 async press",   32'(btn_press),   32'h0);
    check("t6 async release", 32'(btn_release), 32'h0);
    tick(3);
    check("t6 held level", 32'(btn_level), 32'h0);
    reset_n = 1'b1;
    tick(10);
    check("t6 e10 level", 32'(btn_level), 32'h0);
    tick(1);
    check("t6 e11 level", 32'(btn_level), 32'h5);
    check("t6 e11 press", 32'(btn_press), 32'h5);
    tick(3);
    check_counts("t6", 1, 0, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
